// File: rtl/ifm_pingpong_writer_cu_pkg.sv
// Shared definitions for the IFM ping-pong writer control unit.
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
package ifm_pingpong_writer_cu_pkg;

   // Read-side issue handshake states
   typedef enum logic [1:0] {
      ISSUE_IDLE = 2'd0,
      ISSUE_ACK  = 2'd1,
      ISSUE_BUSY = 2'd2
   } issue_state_t;

   // Pixels in one channel slice of a square feature map
   function automatic int slice_pixels(input int ifm_size);
      return ifm_size * ifm_size;
   endfunction

endpackage

// File: rtl/pingpong_bank_tracker.sv
// Tracks occupancy of the two IFM banks plus the write and read bank pointers.
// Latency: set/clear take effect on the next clock edge.
// Backpressure: none here; the caller gates i_set on ~full[wr] and i_clr on full[rd].
// Ports: i_clk, i_reset (sync, high); i_set marks the write bank full and advances it;
//        i_clr empties the read bank and advances it; o_full, o_wr_bank, o_rd_bank.
module pingpong_bank_tracker (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_set,
   input  logic       i_clr,
   output logic [1:0] o_full,
   output logic       o_wr_bank,
   output logic       o_rd_bank
);

   logic [1:0] r_full;
   logic [1:0] w_full_nxt;
   logic       r_wr_bank;
   logic       r_rd_bank;

   // Set and clear can land in the same cycle; they always target different
   // banks because a bank is only written while empty and only released while full.
   always_comb begin
      w_full_nxt = r_full;
      if (i_set) w_full_nxt[r_wr_bank] = 1'b1;
      if (i_clr) w_full_nxt[r_rd_bank] = 1'b0;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_full    <= 2'b00;
         r_wr_bank <= 1'b0;
         r_rd_bank <= 1'b0;
      end else begin
         r_full <= w_full_nxt;
         if (i_set) r_wr_bank <= ~r_wr_bank;
         if (i_clr) r_rd_bank <= ~r_rd_bank;
      end
   end

   assign o_full    = r_full;
   assign o_wr_bank = r_wr_bank;
   assign o_rd_bank = r_rd_bank;

endmodule

// File: rtl/ifm_pingpong_writer_cu.sv
// Writes IFM channel slices into ping-pong banks and hands each slice to the conv CU.
// Latency: write strobe combinational; slice done at t -> start_to_next at t+2.
// Backpressure: in_ready drops while the write bank is still held by the consumer.
// Ports: i_clk, i_reset (sync, high); i_in_valid/o_in_ready pixel stream;
//        o_ifm_enable_write, o_ifm_address_write, o_bank_sel_write bank write side;
//        o_bank_sel_read, o_depth_index_read slice offered to consumer;
//        o_start_to_next / i_end_from_next consumer handshake; o_layer_done end of pass.
module ifm_pingpong_writer_cu
   import ifm_pingpong_writer_cu_pkg::*;
#(
   parameter int IFM_SIZE         = 9,
   parameter int IFM_DEPTH        = 28,
   parameter int ADDRESS_SIZE_IFM = $clog2(slice_pixels(IFM_SIZE)),
   parameter int DEPTH_W          = $clog2(IFM_DEPTH)
) (
   input  logic                        i_clk,
   input  logic                        i_reset,
   input  logic                        i_in_valid,
   output logic                        o_in_ready,
   output logic                        o_ifm_enable_write,
   output logic [ADDRESS_SIZE_IFM-1:0] o_ifm_address_write,
   output logic                        o_bank_sel_write,
   output logic                        o_bank_sel_read,
   output logic [DEPTH_W-1:0]          o_depth_index_read,
   output logic                        o_start_to_next,
   input  logic                        i_end_from_next,
   output logic                        o_layer_done
);

   localparam logic [ADDRESS_SIZE_IFM-1:0] LAST_ADDR  = ADDRESS_SIZE_IFM'(slice_pixels(IFM_SIZE) - 1);
   localparam logic [DEPTH_W-1:0]          LAST_DEPTH = DEPTH_W'(IFM_DEPTH - 1);

   logic [1:0]                  w_full;
   logic                        w_wr_bank;
   logic                        w_rd_bank;
   logic                        w_accept;
   logic                        w_slice_done;
   logic                        w_start;
   logic                        w_release;
   issue_state_t                r_state;
   issue_state_t                w_state_nxt;
   logic [ADDRESS_SIZE_IFM-1:0] r_addr;
   logic [DEPTH_W-1:0]          r_wr_depth;
   logic [DEPTH_W-1:0]          r_rd_depth;
   logic                        r_start;
   logic                        r_layer_done;

   assign o_in_ready   = ~w_full[w_wr_bank];
   assign w_accept     = i_in_valid & o_in_ready;
   assign w_slice_done = w_accept & (r_addr == LAST_ADDR);

   pingpong_bank_tracker u_bank_tracker (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_set     (w_slice_done),
      .i_clr     (w_release),
      .o_full    (w_full),
      .o_wr_bank (w_wr_bank),
      .o_rd_bank (w_rd_bank)
   );

   // Issue FSM: start only when the consumer is idle, wait for it to go busy
   // (so a still-high idle level is not mistaken for completion), then release.
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_release   = 1'b0;
      case (r_state)
         ISSUE_IDLE: begin
            if (w_full[w_rd_bank] && i_end_from_next) begin
               w_start     = 1'b1;
               w_state_nxt = ISSUE_ACK;
            end
         end
         ISSUE_ACK: begin
            if (!i_end_from_next) w_state_nxt = ISSUE_BUSY;
         end
         ISSUE_BUSY: begin
            if (i_end_from_next) begin
               w_release   = 1'b1;
               w_state_nxt = ISSUE_IDLE;
            end
         end
         default: w_state_nxt = ISSUE_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= ISSUE_IDLE;
         r_start      <= 1'b0;
         r_layer_done <= 1'b0;
         r_rd_depth   <= '0;
         r_addr       <= '0;
         r_wr_depth   <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_start      <= w_start;
         r_layer_done <= w_release && (r_rd_depth == LAST_DEPTH);
         if (w_release) begin
            r_rd_depth <= (r_rd_depth == LAST_DEPTH) ? '0 : r_rd_depth + 1'b1;
         end
         if (w_accept) begin
            if (w_slice_done) begin
               r_addr     <= '0;
               r_wr_depth <= (r_wr_depth == LAST_DEPTH) ? '0 : r_wr_depth + 1'b1;
            end else begin
               r_addr <= r_addr + 1'b1;
            end
         end
      end
   end

   assign o_ifm_enable_write  = w_accept;
   assign o_ifm_address_write = r_addr;
   assign o_bank_sel_write    = w_wr_bank;
   assign o_bank_sel_read     = w_rd_bank;
   assign o_depth_index_read  = r_rd_depth;
   assign o_start_to_next     = r_start;
   assign o_layer_done        = r_layer_done;

endmodule

// File: tb/tb_ifm_pingpong_writer_cu.sv
// Randomized bench for ifm_pingpong_writer_cu against a slice-count reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_ifm_pingpong_writer_cu;

   localparam int SZ    = 3;
   localparam int DEPTH = 2;
   localparam int SLICE = SZ * SZ;
   localparam int AW    = $clog2(SLICE);
   localparam int DW    = $clog2(DEPTH);
   localparam int NCYC  = 4000;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic          bank_w;
   logic          bank_r;
   logic [DW-1:0] depth_r;
   logic          start;
   logic          end_n;
   logic          layer_done;

   always #5 clk = ~clk;

   ifm_pingpong_writer_cu #(
      .IFM_SIZE  (SZ),
      .IFM_DEPTH (DEPTH)
   ) dut (
      .i_clk               (clk),
      .i_reset             (rst),
      .i_in_valid          (in_valid),
      .o_in_ready          (in_ready),
      .o_ifm_enable_write  (wr_en),
      .o_ifm_address_write (wr_addr),
      .o_bank_sel_write    (bank_w),
      .o_bank_sel_read     (bank_r),
      .o_depth_index_read  (depth_r),
      .o_start_to_next     (start),
      .i_end_from_next     (end_n),
      .o_layer_done        (layer_done)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
   endtask

   // Reference model: pixels accepted since reset, slices released, starts issued.
   // Slices written = pix/SLICE; banks in use = written - released.
   int pix, rel, starts, wc, run_len, n_start_seen, n_ld_seen, n_stall;
   bit acked, exp_start, exp_ld, exp_ready, nxt_start, nxt_ld, run_val;

   task automatic model_reset();
      pix = 0; rel = 0; starts = 0; acked = 0; exp_start = 0; exp_ld = 0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; end_n = 1'b1;
      run_len = 0; run_val = 1'b1; n_start_seen = 0; n_ld_seen = 0; n_stall = 0;
      model_reset();
      repeat (2) @(posedge clk);

      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(posedge clk);
         #1;
         // Directed mid-slice reset early on, plus rare random resets.
         rst      = (cyc == 6) || ($urandom_range(0, 399) == 0);
         in_valid = ($urandom_range(0, 9) < 8);
         // Consumer idle level driven in random runs; long low runs fill both banks.
         if (run_len == 0) begin
            run_val = ($urandom_range(0, 1) == 1);
            run_len = run_val ? $urandom_range(1, 8) : $urandom_range(1, 30);
         end
         end_n = run_val;
         run_len--;

         @(negedge clk);
         wc        = pix / SLICE;
         exp_ready = ((wc - rel) < 2);
         chk_eq("in_ready",    {31'd0, in_ready},   {31'd0, exp_ready});
         chk_eq("wr_enable",   {31'd0, wr_en},      {31'd0, in_valid & exp_ready});
         chk_eq("wr_addr",     32'(wr_addr),        32'(pix % SLICE));
         chk_eq("bank_sel_wr", {31'd0, bank_w},     32'(wc % 2));
         chk_eq("bank_sel_rd", {31'd0, bank_r},     32'(rel % 2));
         chk_eq("depth_rd",    32'(depth_r),        32'(rel % DEPTH));
         chk_eq("start",       {31'd0, start},      {31'd0, exp_start});
         chk_eq("layer_done",  {31'd0, layer_done}, {31'd0, exp_ld});
         if (exp_start) n_start_seen++;
         if (exp_ld) n_ld_seen++;
         if (!exp_ready) n_stall++;

         if (rst) begin
            model_reset();
         end else begin
            nxt_start = 1'b0;
            nxt_ld    = 1'b0;
            if (exp_start) begin
               starts++;
               acked = 1'b0;
            end
            if (starts > rel) begin
               // Consumer must show busy after the start before idle means done.
               if (!acked) begin
                  if (!end_n) acked = 1'b1;
               end else if (end_n) begin
                  nxt_ld = ((rel % DEPTH) == DEPTH - 1);
                  rel++;
               end
            end else if ((wc > rel) && end_n) begin
               nxt_start = 1'b1;
            end
            if (in_valid && exp_ready) pix++;
            exp_start = nxt_start;
            exp_ld    = nxt_ld;
         end
      end

      chk_eq("starts_observed", {31'd0, (n_start_seen > 10)}, 32'd1);
      chk_eq("layer_done_seen", {31'd0, (n_ld_seen > 3)},     32'd1);
      chk_eq("stall_observed",  {31'd0, (n_stall > 0)},       32'd1);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
